// File: rtl/urv_cfg.sv
// Shared memory-map, width and CLINT constants for the uRV core and its
// peripherals, plus the byte-strobe merge helper used by the CLINT registers.
package urv_cfg;

    localparam logic [31:0] MEM_BASE_ADDR_CLINT = 32'h0005_0000;

    localparam int MEM_ADDR_W     = 32;
    localparam int MEM_DATA_W     = 32;
    localparam int MEM_MASK_W     = 4;
    localparam int CSR_TIME_W     = 64;
    localparam int CSR_TIME_CMP_W = 64;

    localparam logic [11:0] CLINT_MSIP_OFS        = 12'h000;
    localparam logic [11:0] CLINT_MTIMECMP_LO_OFS = 12'h008;
    localparam logic [11:0] CLINT_MTIMECMP_HI_OFS = 12'h00C;
    localparam logic [11:0] CLINT_MTIME_LO_OFS    = 12'h010;
    localparam logic [11:0] CLINT_MTIME_HI_OFS    = 12'h014;
    localparam logic [11:0] CLINT_PRESCALE_OFS    = 12'h01C;

    localparam int CLINT_PRESCALE_W = 16;

    typedef enum logic {
        CLINT_IDLE,
        CLINT_RESP
    } clint_state_e;

    // Byte-strobe merge of one 32-bit register half.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/urv_clint_if.sv
// Request/response data-bus bundle between the core and the CLINT slave.
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// a response transfers where rsp_valid && rsp_ready; while valid is high and
// ready is low the sender holds every payload signal stable.
interface urv_clint_if #(
    parameter int ADDR_W = urv_cfg::MEM_ADDR_W,
    parameter int DATA_W = urv_cfg::MEM_DATA_W,
    parameter int MASK_W = urv_cfg::MEM_MASK_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/urv_clint_timer.sv
// CLINT timebase: free-running mtime, mtimecmp and the registered timer_irq.
// With URV_CLINT_PRESCALE_EN defined, a 16-bit PRESCALE divider gates the tick.
module urv_clint_timer
    import urv_cfg::*;
#(
    parameter int TIME_W = CSR_TIME_W,
    parameter int CMP_W  = CSR_TIME_CMP_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int MASK_W = MEM_MASK_W
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        wr_time_lo,
    input  logic                        wr_time_hi,
    input  logic                        wr_cmp_lo,
    input  logic                        wr_cmp_hi,
`ifdef URV_CLINT_PRESCALE_EN
    input  logic                        wr_prescale,
    output logic [CLINT_PRESCALE_W-1:0] prescale_o,
`endif
    input  logic [DATA_W-1:0]           wdata,
    input  logic [MASK_W-1:0]           wmask,
    output logic [TIME_W-1:0]           mtime_o,
    output logic [CMP_W-1:0]            mtimecmp_o,
    output logic                        timer_irq
);
    logic [TIME_W-1:0] mtime_q, mtime_d;
    logic [CMP_W-1:0]  cmp_q, cmp_d;
    logic              irq_q, irq_d;
    logic              tick;

`ifdef URV_CLINT_PRESCALE_EN
    logic [CLINT_PRESCALE_W-1:0] pre_q, pre_d, cnt_q, cnt_d;

    // Tick on the cycle the counter matches PRESCALE; a PRESCALE write restarts the count.
    always_comb begin
        tick  = (cnt_q == pre_q);
        cnt_d = tick ? '0 : cnt_q + CLINT_PRESCALE_W'(1);
        pre_d = pre_q;
        if (wr_prescale) begin
            cnt_d       = '0;
            pre_d[7:0]  = wmask[0] ? wdata[7:0]  : pre_q[7:0];
            pre_d[15:8] = wmask[1] ? wdata[15:8] : pre_q[15:8];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign prescale_o = pre_q;
`else
    assign tick = 1'b1;
`endif

    // Any mtime write freezes the whole 64-bit count for that cycle.
    always_comb begin
        mtime_d = tick ? mtime_q + TIME_W'(1) : mtime_q;
        if (wr_time_lo || wr_time_hi) mtime_d = mtime_q;
        if (wr_time_lo) mtime_d[DATA_W-1:0]      = byte_merge(mtime_q[DATA_W-1:0], wdata, wmask);
        if (wr_time_hi) mtime_d[TIME_W-1:DATA_W] = byte_merge(mtime_q[TIME_W-1:DATA_W], wdata, wmask);

        cmp_d = cmp_q;
        if (wr_cmp_lo) cmp_d[DATA_W-1:0]     = byte_merge(cmp_q[DATA_W-1:0], wdata, wmask);
        if (wr_cmp_hi) cmp_d[CMP_W-1:DATA_W] = byte_merge(cmp_q[CMP_W-1:DATA_W], wdata, wmask);

        irq_d = (mtime_d >= cmp_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = cmp_q;
    assign timer_irq  = irq_q;
endmodule

// File: rtl/urv_clint.sv
// uRV core-local interruptor: bus slave FSM, register decode and msip/soft_irq.
// Optional PRESCALE register at 0x01C is built when URV_CLINT_PRESCALE_EN is defined.
module urv_clint
    import urv_cfg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int MASK_W = MEM_MASK_W,
    parameter int TIME_W = CSR_TIME_W,
    parameter int CMP_W  = CSR_TIME_CMP_W
) (
    input  logic              clk,
    input  logic              rstn,
    urv_clint_if.slave        bus,
    output logic              timer_irq,
    output logic              soft_irq,
    output logic [TIME_W-1:0] mtime_o,
    output clint_state_e      dbg_state
);
    clint_state_e      state_q, state_d;
    logic              req_ready, rsp_valid, accept, wr, mapped;
    logic [11:0]       ofs;
    logic [DATA_W-1:0] rd_val, rdata_q, rdata_d;
    logic              err_q, err_d, msip_q, msip_d, soft_q;
    logic [TIME_W-1:0] mtime;
    logic [CMP_W-1:0]  mtimecmp;
    logic              unused_addr_hi;
`ifdef URV_CLINT_PRESCALE_EN
    logic [CLINT_PRESCALE_W-1:0] prescale;
`endif

    assign ofs            = bus.req_addr[11:0];
    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:12];

    // In RESP the next request is taken only when the current response drains.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            CLINT_IDLE: begin
                accept = bus.req_valid;
                if (bus.req_valid) state_d = CLINT_RESP;
            end
            CLINT_RESP: begin
                rsp_valid = 1'b1;
                req_ready = bus.rsp_ready;
                accept    = bus.rsp_ready && bus.req_valid;
                if (bus.rsp_ready && !bus.req_valid) state_d = CLINT_IDLE;
            end
            default: state_d = CLINT_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (ofs)
            CLINT_MSIP_OFS:        rd_val = {{(DATA_W-1){1'b0}}, msip_q};
            CLINT_MTIMECMP_LO_OFS: rd_val = mtimecmp[DATA_W-1:0];
            CLINT_MTIMECMP_HI_OFS: rd_val = mtimecmp[CMP_W-1:DATA_W];
            CLINT_MTIME_LO_OFS:    rd_val = mtime[DATA_W-1:0];
            CLINT_MTIME_HI_OFS:    rd_val = mtime[TIME_W-1:DATA_W];
`ifdef URV_CLINT_PRESCALE_EN
            CLINT_PRESCALE_OFS:    rd_val = {{(DATA_W-CLINT_PRESCALE_W){1'b0}}, prescale};
`endif
            default:               mapped = 1'b0;
        endcase

        wr      = accept && bus.req_wen;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            rdata_d = (bus.req_wen || !mapped) ? '0 : rd_val;
            err_d   = !mapped;
        end
        msip_d = (wr && ofs == CLINT_MSIP_OFS && bus.req_wmask[0]) ? bus.req_wdata[0] : msip_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= CLINT_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            msip_q  <= 1'b0;
            soft_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            msip_q  <= msip_d;
            soft_q  <= msip_d;
        end
    end

    urv_clint_timer #(
        .TIME_W (TIME_W),
        .CMP_W  (CMP_W),
        .DATA_W (DATA_W),
        .MASK_W (MASK_W)
    ) u_timer (
        .clk         (clk),
        .rstn        (rstn),
        .wr_time_lo  (wr && ofs == CLINT_MTIME_LO_OFS),
        .wr_time_hi  (wr && ofs == CLINT_MTIME_HI_OFS),
        .wr_cmp_lo   (wr && ofs == CLINT_MTIMECMP_LO_OFS),
        .wr_cmp_hi   (wr && ofs == CLINT_MTIMECMP_HI_OFS),
`ifdef URV_CLINT_PRESCALE_EN
        .wr_prescale (wr && ofs == CLINT_PRESCALE_OFS),
        .prescale_o  (prescale),
`endif
        .wdata       (bus.req_wdata),
        .wmask       (bus.req_wmask),
        .mtime_o     (mtime),
        .mtimecmp_o  (mtimecmp),
        .timer_irq   (timer_irq)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign soft_irq      = soft_q;
    assign mtime_o       = mtime;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_urv_clint.sv
// Self-checking bench for urv_clint: directed register-map/handshake tests
// plus randomized accesses against a cycle-indexed reference model.
module tb_urv_clint;
    import urv_cfg::*;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         timer_irq, soft_irq;
    logic [63:0]  mtime_o;
    clint_state_e dbg_state;

    urv_clint_if bus ();

    urv_clint dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq),
        .mtime_o   (mtime_o),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- reference model ----------------
    // mtime after edge e = anchor value + number of ticks in (anchor edge, e];
    // ticks fall on edges where (e - phase) is a multiple of (prescale + 1).
    logic [63:0] m_val;
    int          m_e, m_ph, m_p;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [63:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic void model_reset();
        m_val = 64'd0; m_e = 0; m_ph = 0; m_p = 0;
        m_cmp = {64{1'b1}}; m_msip = 1'b0;
    endfunction

    function automatic logic [63:0] mtime_at(input int e);
        int per;
        per = m_p + 1;
        return m_val + 64'((e - m_ph) / per - (m_e - m_ph) / per);
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] d,
                                            input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? d[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // Expected {err, rdata} for a request accepted at edge e.
    function automatic logic [63:0] exp_rsp(input int e, input logic [11:0] ofs, input logic wen);
        logic [31:0] d;
        logic        err;
        logic [63:0] t;
        t = mtime_at(e - 1);
        d = 32'd0;
        err = 1'b0;
        case (ofs)
            12'h000: d = {31'd0, m_msip};
            12'h008: d = m_cmp[31:0];
            12'h00C: d = m_cmp[63:32];
            12'h010: d = t[31:0];
            12'h014: d = t[63:32];
`ifdef URV_CLINT_PRESCALE_EN
            12'h01C: d = 32'(m_p);
`endif
            default: err = 1'b1;
        endcase
        if (wen || err) d = 32'd0;
        return {31'd0, err, d};
    endfunction

    function automatic void apply_write(input int e, input logic [11:0] ofs,
                                        input logic [31:0] d, input logic [3:0] m);
        logic [63:0] t;
        case (ofs)
            12'h000: if (m[0]) m_msip = d[0];
            12'h008: m_cmp[31:0]  = merge32(m_cmp[31:0], d, m);
            12'h00C: m_cmp[63:32] = merge32(m_cmp[63:32], d, m);
            12'h010: begin t = mtime_at(e - 1); t[31:0]  = merge32(t[31:0], d, m);  m_val = t; m_e = e; end
            12'h014: begin t = mtime_at(e - 1); t[63:32] = merge32(t[63:32], d, m); m_val = t; m_e = e; end
`ifdef URV_CLINT_PRESCALE_EN
            12'h01C: begin
                t = mtime_at(e);
                m_val = t; m_e = e; m_ph = e;
                m_p = int'(merge32(32'(m_p), d, m) & 32'h0000_FFFF);
            end
`endif
            default: ;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_state(input string tag);
        logic [63:0] t;
        t = mtime_at(cyc);
        check_val({tag, "/mtime"}, mtime_o, t);
        check_val({tag, "/timer_irq"}, 64'(timer_irq), 64'(t >= m_cmp));
        check_val({tag, "/soft_irq"}, 64'(soft_irq), 64'(m_msip));
    endtask

    task automatic check_rsp(input string tag, output logic [63:0] exp);
        if (exp_q.size() == 0) begin
            exp = 64'd0;
            check_val({tag, "/queue_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check_val({tag, "/rsp"}, {31'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata},
                      {31'd0, 1'b1, exp[32:0]});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic wen, input logic [11:0] ofs,
                             input logic [31:0] d, input logic [3:0] m);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = {20'($urandom), ofs};
        bus.req_wdata = d;
        bus.req_wmask = m;
        exp_q.push_back(exp_rsp(cyc + 1, ofs, wen));
    endtask

    task automatic access(input string tag, input logic wen, input logic [11:0] ofs,
                          input logic [31:0] d, input logic [3:0] m);
        logic [63:0] e;
        drive_req(wen, ofs, d, m);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        if (wen) apply_write(cyc, ofs, d, m);
        bus.req_valid = 1'b0;
        check_rsp(tag, e);
        check_state(tag);
        @(negedge clk);
        check_val({tag, "/back_idle"}, {62'd0, bus.rsp_valid, bus.req_ready}, 64'b01);
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            check_state(tag);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [11:0] ofs_tab[10] = '{12'h000, 12'h008, 12'h00C, 12'h010, 12'h014,
                                 12'h01C, 12'h020, 12'h004, 12'h018, 12'h000};
    logic [11:0] b2b_tab[4] = '{12'h000, 12'h008, 12'h00C, 12'h010};

    initial begin
        logic [63:0] e;
        logic [11:0] o;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wmask = '0; bus.rsp_ready = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_val("reset/rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 64'd0);
        check_val("reset/irqs", {timer_irq, soft_irq}, 64'd0);
        check_val("reset/mtime", mtime_o, 64'd0);
        rstn = 1'b1;
        check_val("reset/req_ready", 64'(bus.req_ready), 64'd1);
        check_val("reset/state", 64'(dbg_state), 64'(CLINT_IDLE));

        idle("idle", 10);
        access("rd_mtime_lo", 1'b0, 12'h010, 32'd0, 4'h0);
        access("rd_cmp_hi", 1'b0, 12'h00C, 32'd0, 4'h0);

        access("wr_cmp_hi", 1'b1, 12'h00C, 32'd0, 4'hF);
        e = mtime_at(cyc) + 64'd20;
        access("wr_cmp_lo", 1'b1, 12'h008, e[31:0], 4'hF);
        idle("irq_rise", 30);
        check_val("irq_high", 64'(timer_irq), 64'd1);
        access("cmp_lo_max", 1'b1, 12'h008, 32'hFFFF_FFFF, 4'hF);
        idle("irq_fall", 3);

        access("wr_mtime_hi", 1'b1, 12'h014, 32'hFFFF_FFFF, 4'hF);
        access("wr_mtime_lo", 1'b1, 12'h010, 32'hFFFF_FFFF, 4'hF);
        idle("wrap", 3);

        access("msip_set", 1'b1, 12'h000, 32'h3, 4'h1);
        access("msip_rd", 1'b0, 12'h000, 32'd0, 4'h0);
        access("msip_nomask", 1'b1, 12'h000, 32'h0, 4'h0);
        access("msip_rd2", 1'b0, 12'h000, 32'd0, 4'h0);

        access("unmapped_rd", 1'b0, 12'h020, 32'd0, 4'h0);
        access("unmapped_wr", 1'b1, 12'h024, 32'h1234_5678, 4'hF);
        access("prescale_rd", 1'b0, 12'h01C, 32'd0, 4'h0);

        // Back-to-back reads, one accepted per cycle.
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, b2b_tab[i], 32'd0, 4'h0);
            @(negedge clk);
            check_rsp("b2b", e);
            check_state("b2b");
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_val("b2b/end", 64'(bus.rsp_valid), 64'd0);

        // Response stall: payload held, no new request taken.
        drive_req(1'b0, 12'h010, 32'd0, 4'h0);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_rsp("stall_first", e);
        repeat (3) begin
            @(negedge clk);
            check_val("stall/rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, e[32:0]});
            check_val("stall/req_ready", 64'(bus.req_ready), 64'd0);
            check_state("stall");
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_val("stall/end", 64'(bus.rsp_valid), 64'd0);

`ifdef URV_CLINT_PRESCALE_EN
        access("prescale_wr", 1'b1, 12'h01C, 32'hABCD_0003, 4'hF);
        access("prescale_rd3", 1'b0, 12'h01C, 32'd0, 4'h0);
        idle("prescale", 12);
        access("prescale_zero", 1'b1, 12'h01C, 32'd0, 4'h3);
`endif

        repeat (60) begin
            o = ofs_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) o = 12'($urandom);
            access("rand", 1'($urandom), o, $urandom, 4'($urandom_range(0, 15)));
            idle("rand_gap", $urandom_range(0, 3));
        end

        // Reset in the middle of a stalled response.
        drive_req(1'b0, 12'h014, 32'd0, 4'h0);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_rsp("midrst_first", e);
        rstn = 1'b0;
        #1;
        check_val("midrst/rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 64'd0);
        check_val("midrst/state", 64'(dbg_state), 64'(CLINT_IDLE));
        check_val("midrst/mtime", mtime_o, 64'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        idle("post_rst", 4);
        access("post_rst_rd", 1'b0, 12'h008, 32'd0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
